mips_multi_cycle_controller: RTL and testbench

Multi-cycle sequencer for the MIPS core. It replaces the single-cycle combinational controller when the datapath is re-used across cycles and shares one memory port between fetch and data. It takes the opcode and func fields from the instruction register, the ALU zero flag and a memory ready handshake. It drives every datapath mux select, register write strobe and memory strobe, one state per cycle.

---
 rtl/mips_multi_cycle_controller_if.sv | 34 +++
 rtl/mips_multi_cycle_controller.sv | 196 +++++++++++++++++++
 tb/tb_mips_multi_cycle_controller.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multi_cycle_controller_if.sv
// rtl/mips_multi_cycle_controller_if.sv - control bundle between the MIPS sequencer and its datapath
interface mips_multi_cycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  opcode, func, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
           alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write, instr_done, state
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
           alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write, instr_done, state
  );
endinterface

// File: rtl/mips_multi_cycle_controller.sv
// rtl/mips_multi_cycle_controller.sv - multi-cycle MIPS sequencer driving datapath selects and strobes
module mips_multi_cycle_controller (
  input logic                          clk,
  input logic                          rst,
  mips_multi_cycle_controller_if.master bus
);
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEM_ADR = 4'd3;
  localparam logic [3:0] S_MEM_RD  = 4'd4;
  localparam logic [3:0] S_MEM_WB  = 4'd5;
  localparam logic [3:0] S_MEM_WR  = 4'd6;
  localparam logic [3:0] S_R_EX    = 4'd7;
  localparam logic [3:0] S_R_WB    = 4'd8;
  localparam logic [3:0] S_BEQ     = 4'd9;
  localparam logic [3:0] S_I_EX    = 4'd10;
  localparam logic [3:0] S_I_WB    = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;
  localparam logic [3:0] S_JAL     = 4'd13;
  localparam logic [3:0] S_JR      = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       op_legal;
  logic [2:0] r_alu_ctrl;

  // Zero is consumed by the datapath together with pc_write_cond.
  logic unused_zero;
  assign unused_zero = bus.zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  assign bus.state = state_q;

  always_comb begin
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J, OP_JAL: op_legal = 1'b1;
      default:                                                        op_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.func)
      6'b100000: r_alu_ctrl = ALU_ADD;
      6'b100010: r_alu_ctrl = ALU_SUB;
      6'b100100: r_alu_ctrl = ALU_AND;
      6'b100101: r_alu_ctrl = ALU_OR;
      6'b101010: r_alu_ctrl = ALU_SLT;
      default:   r_alu_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADR;
          OP_RTYPE:         state_d = (bus.func == FN_JR) ? S_JR : S_R_EX;
          OP_BEQ:           state_d = S_BEQ;
          OP_ADDI, OP_SLTI: state_d = S_I_EX;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:  state_d = S_FETCH;
      S_MEM_WR:  state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EX:    state_d = S_R_WB;
      S_R_WB:    state_d = S_FETCH;
      S_BEQ:     state_d = S_FETCH;
      S_I_EX:    state_d = S_I_WB;
      S_I_WB:    state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_JAL:     state_d = S_FETCH;
      S_JR:      state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore decode; only the FETCH loads, MEM_WR/DECODE completion and EX alu_ctrl look at inputs.
  always_comb begin
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = 2'b00;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_ctrl      = ALU_ADD;
    bus.reg_dst       = 2'b00;
    bus.mem_to_reg    = 2'b00;
    bus.reg_write     = 1'b0;
    bus.instr_done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b  = 2'b11;
        bus.instr_done = ~op_legal;
      end
      S_MEM_ADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        bus.mem_to_reg = 2'b01;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_R_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = r_alu_ctrl;
      end
      S_R_WB: begin
        bus.reg_dst    = 2'b01;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BEQ: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_ctrl      = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = 2'b01;
        bus.instr_done    = 1'b1;
      end
      S_I_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_ctrl  = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_src     = 2'b10;
        bus.instr_done = 1'b1;
      end
      S_JAL: begin
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 2'b10;
        bus.reg_write  = 1'b1;
        bus.pc_write   = 1'b1;
        bus.pc_src     = 2'b10;
        bus.instr_done = 1'b1;
      end
      S_JR: begin
        bus.pc_write   = 1'b1;
        bus.pc_src     = 2'b11;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_multi_cycle_controller.sv
// tb/tb_mips_multi_cycle_controller.sv - self-checking bench for the multi-cycle MIPS sequencer
module tb_mips_multi_cycle_controller;
  logic clk;
  logic rst;
  mips_multi_cycle_controller_if bus ();

  mips_multi_cycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       mr;
    logic [3:0] st;
    logic [2:0] tag;
    logic [2:0] val;
  } ent_t;

  ent_t sb[$];
  int compared = 0;
  int mismatched = 0;

  // Strobe order: mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, instr_done
  function automatic logic [6:0] exp_strobes(input logic [3:0] st, input logic mr, input logic [5:0] op);
    logic legal;
    legal = (op == 6'h23) || (op == 6'h2b) || (op == 6'h00) || (op == 6'h04) ||
            (op == 6'h08) || (op == 6'h0a) || (op == 6'h02) || (op == 6'h03);
    case (st)
      4'd1:       return {1'b1, 1'b0, mr, mr, 3'b000};
      4'd2:       return {6'b000000, ~legal};
      4'd4:       return 7'b1000000;
      4'd5:       return 7'b0000011;
      4'd6:       return {1'b0, 1'b1, 4'b0000, mr};
      4'd8, 4'd11: return 7'b0000011;
      4'd9:       return 7'b0000101;
      4'd12, 4'd14: return 7'b0001001;
      4'd13:      return 7'b0001011;
      default:    return 7'b0000000;
    endcase
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic zero, input logic mr,
                      input logic [3:0] st, input logic [2:0] tag, input logic [2:0] val);
    ent_t e;
    e.op = op; e.fn = fn; e.zero = zero; e.mr = mr; e.st = st; e.tag = tag; e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_fetch(input logic [5:0] op, input logic [5:0] fn, input int waits);
    for (int i = 0; i < waits; i++) push(op, fn, 1'b0, 1'b0, 4'd1, 3'd5, 3'd0);
    push(op, fn, 1'b0, 1'b1, 4'd1, 3'd5, 3'd0);
  endtask

  // Caller stands at a negedge; each entry covers one clock period.
  task automatic run_sb();
    ent_t e;
    logic [6:0] obs;
    logic [6:0] expv;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.opcode = e.op; bus.func = e.fn; bus.zero = e.zero; bus.mem_ready = e.mr;
      #1;
      compared++;
      if (bus.state !== e.st) begin
        mismatched++;
        $display("FAIL state: got %0d expected %0d", bus.state, e.st);
      end
      obs  = {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_write_cond,
              bus.reg_write, bus.instr_done};
      expv = exp_strobes(e.st, e.mr, e.op);
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("FAIL strobes in state %0d: got %b expected %b", e.st, obs, expv);
      end
      case (e.tag)
        3'd1: begin
          compared++;
          if ({bus.reg_dst, bus.mem_to_reg} !== 4'b0100) begin
            mismatched++;
            $display("FAIL r_wb_selects: got %b expected 0100", {bus.reg_dst, bus.mem_to_reg});
          end
        end
        3'd2: begin
          compared++;
          if ({bus.pc_src, bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b} !== 8'b01_110_1_00) begin
            mismatched++;
            $display("FAIL beq_selects: got %b expected 01110100",
                     {bus.pc_src, bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b});
          end
        end
        3'd3: begin
          compared++;
          if ({bus.reg_dst, bus.mem_to_reg, bus.pc_src} !== 6'b10_10_10) begin
            mismatched++;
            $display("FAIL jal_selects: got %b expected 101010", {bus.reg_dst, bus.mem_to_reg, bus.pc_src});
          end
        end
        3'd4: begin
          compared++;
          if (bus.alu_ctrl !== e.val) begin
            mismatched++;
            $display("FAIL alu_ctrl op=%b fn=%b: got %b expected %b", e.op, e.fn, bus.alu_ctrl, e.val);
          end
        end
        3'd5: begin
          compared++;
          if ({bus.i_or_d, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.pc_src} !== 9'b0_0_01_010_00) begin
            mismatched++;
            $display("FAIL fetch_selects: got %b expected 000101000",
                     {bus.i_or_d, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.pc_src});
          end
        end
        3'd6: begin
          compared++;
          if (bus.i_or_d !== 1'b1) begin
            mismatched++;
            $display("FAIL i_or_d data access: got %b expected 1", bus.i_or_d);
          end
        end
        3'd7: begin
          compared++;
          if (bus.pc_src !== e.val[1:0]) begin
            mismatched++;
            $display("FAIL pc_src in state %0d: got %b expected %b", e.st, bus.pc_src, e.val[1:0]);
          end
        end
        default: ;
      endcase
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.opcode = 6'd0; bus.func = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b1;
    push(6'd0, 6'd0, 1'b0, 1'b1, 4'd0, 3'd0, 3'd0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.opcode = 6'd0; bus.func = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    compared++;
    if ({bus.state, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_write_cond,
         bus.reg_write, bus.instr_done} !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_strobes: state=%0d strobes nonzero", bus.state);
    end
    compared++;
    if ({bus.i_or_d, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.reg_dst,
         bus.mem_to_reg} !== 13'b0_00_0_00_010_00_00) begin
      mismatched++;
      $display("FAIL reset_selects: got %b expected 0000000100000",
               {bus.i_or_d, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.reg_dst, bus.mem_to_reg});
    end
  endtask

  task automatic test_rtype();
    do_reset();
    push_fetch(6'h00, 6'b100000, 0);
    push(6'h00, 6'b100000, 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
    push(6'h00, 6'b100000, 1'b0, 1'b1, 4'd7, 3'd4, 3'b010);
    push(6'h00, 6'b100000, 1'b0, 1'b1, 4'd8, 3'd1, 3'd0);
    push(6'h00, 6'b100000, 1'b0, 1'b1, 4'd1, 3'd5, 3'd0);
    run_sb();
  endtask

  task automatic test_rfunc();
    logic [5:0] fns  [5];
    logic [2:0] alus [5];
    fns  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    alus = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_fetch(6'h00, fns[i], 0);
      push(6'h00, fns[i], 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
      push(6'h00, fns[i], 1'b0, 1'b1, 4'd7, 3'd4, alus[i]);
      push(6'h00, fns[i], 1'b0, 1'b1, 4'd8, 3'd1, 3'd0);
    end
    run_sb();
  endtask

  task automatic test_lw_wait();
    do_reset();
    push_fetch(6'h23, 6'd0, 2);
    push(6'h23, 6'd0, 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
    push(6'h23, 6'd0, 1'b0, 1'b1, 4'd3, 3'd4, 3'b010);
    for (int i = 0; i < 3; i++) push(6'h23, 6'd0, 1'b0, 1'b0, 4'd4, 3'd6, 3'd0);
    push(6'h23, 6'd0, 1'b0, 1'b1, 4'd4, 3'd6, 3'd0);
    push(6'h23, 6'd0, 1'b0, 1'b1, 4'd5, 3'd0, 3'd0);
    push(6'h23, 6'd0, 1'b0, 1'b1, 4'd1, 3'd5, 3'd0);
    run_sb();
  endtask

  task automatic test_sw();
    do_reset();
    push_fetch(6'h2b, 6'd0, 0);
    push(6'h2b, 6'd0, 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
    push(6'h2b, 6'd0, 1'b0, 1'b1, 4'd3, 3'd0, 3'd0);
    push(6'h2b, 6'd0, 1'b0, 1'b0, 4'd6, 3'd6, 3'd0);
    push(6'h2b, 6'd0, 1'b0, 1'b1, 4'd6, 3'd6, 3'd0);
    push(6'h2b, 6'd0, 1'b0, 1'b1, 4'd1, 3'd5, 3'd0);
    run_sb();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int z = 1; z >= 0; z--) begin
      push_fetch(6'h04, 6'd0, 0);
      push(6'h04, 6'd0, z[0], 1'b1, 4'd2, 3'd0, 3'd0);
      push(6'h04, 6'd0, z[0], 1'b1, 4'd9, 3'd2, 3'd0);
    end
    push_fetch(6'h08, 6'd0, 0);
    push(6'h08, 6'd0, 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
    push(6'h08, 6'd0, 1'b0, 1'b1, 4'd10, 3'd4, 3'b010);
    push(6'h08, 6'd0, 1'b0, 1'b1, 4'd11, 3'd0, 3'd0);
    push_fetch(6'h0a, 6'd0, 0);
    push(6'h0a, 6'd0, 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
    push(6'h0a, 6'd0, 1'b0, 1'b1, 4'd10, 3'd4, 3'b111);
    push(6'h0a, 6'd0, 1'b0, 1'b1, 4'd11, 3'd0, 3'd0);
    push_fetch(6'h02, 6'd0, 0);
    push(6'h02, 6'd0, 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
    push(6'h02, 6'd0, 1'b0, 1'b1, 4'd12, 3'd7, 3'b010);
    push_fetch(6'h03, 6'd0, 0);
    push(6'h03, 6'd0, 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
    push(6'h03, 6'd0, 1'b0, 1'b1, 4'd13, 3'd3, 3'd0);
    push_fetch(6'h00, 6'b001000, 0);
    push(6'h00, 6'b001000, 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
    push(6'h00, 6'b001000, 1'b0, 1'b1, 4'd14, 3'd7, 3'b011);
    push_fetch(6'h3f, 6'd0, 0);
    push(6'h3f, 6'd0, 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
    push_fetch(6'h3f, 6'd0, 0);
    run_sb();
  endtask

  task automatic test_reset_abort();
    do_reset();
    push_fetch(6'h2b, 6'd0, 0);
    push(6'h2b, 6'd0, 1'b0, 1'b1, 4'd2, 3'd0, 3'd0);
    push(6'h2b, 6'd0, 1'b0, 1'b1, 4'd3, 3'd0, 3'd0);
    push(6'h2b, 6'd0, 1'b0, 1'b0, 4'd6, 3'd6, 3'd0);
    run_sb();
    #1;
    compared++;
    if ({bus.state, bus.mem_write} !== {4'd6, 1'b1}) begin
      mismatched++;
      $display("FAIL abort_precheck: state=%0d mem_write=%b expected 6/1", bus.state, bus.mem_write);
    end
    rst = 1'b0;
    #1;
    compared++;
    if ({bus.state, bus.mem_write, bus.instr_done} !== {4'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL abort_async: state=%0d mem_write=%b instr_done=%b expected 0/0/0",
               bus.state, bus.mem_write, bus.instr_done);
    end
    @(negedge clk);
    #1;
    compared++;
    if (bus.state !== 4'd0) begin
      mismatched++;
      $display("FAIL abort_hold: state=%0d expected 0", bus.state);
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_rfunc();
    test_lw_wait();
    test_sw();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
